muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside alu_unit in the execute stage. The hazard unit stalls the pipeline while a request is in flight.
- Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Uses a valid/ready handshake on both the request side and the result side. Latency is fixed and data-independent, except for the divide special cases.

Parameters:
- XLEN, DATA_WIDTH (32): operand and result width; must be ≥ 4 and even.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, not overridable.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  abort in-flight operation (pipeline flush).
- valid_i  input  1  request valid.
- ready_o  output  1  unit accepts a request.
- op_i  input  3  muldiv_op_e, RV32M funct3 encoding.
- a_i  input  XLEN  rs1 operand.
- b_i  input  XLEN  rs2 operand.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer takes result.
- result_o  output  XLEN  result.
- busy_o  output  1  state != IDLE.

Behaviour:
- Only clk_i and rst_ni are used for timing: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, busy_o=0, all datapath registers 0.
- States:
  - IDLE: ready_o=1.
  - CALC: XLEN iterations.
  - FIX: sign correction and result selection.
  - DONE: valid_o=1, result_o stable.
- Accept: a request is taken when valid_i && ready_o && !flush_i. op, the operand signs and the operand magnitudes are latched that cycle.
- Signedness:
  - a is signed for MULH, MULHSU, DIV and REM.
  - b is signed for MULH, DIV and REM.
  - MUL is computed as unsigned; its low half is identical either way.
- Multiply: shift-add on magnitudes, 2*XLEN-bit product.
  - Negate the product in FIX if sign_a^sign_b (signed cases only).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes the sign of a.
- Latency: accept in cycle N, CALC in N+1..N+XLEN, FIX in N+XLEN+1, valid_o=1 from N+XLEN+2.
- Divide special cases bypass CALC: accept in cycle N → FIX at N+1 → valid_o at N+2.
  - b==0: DIV/DIVU return all ones; REM/REMU return a.
  - DIV/REM with a==most-negative and b==all ones: DIV returns a; REM returns 0.
- DONE holds valid_o and result_o until ready_i. On the handshake cycle the unit moves to IDLE; a new request is accepted no earlier than the next cycle, so there is no back-to-back accept.
- flush_i has priority in every state. The next state is IDLE, valid_o=0, and result_o keeps its last value. A valid_i asserted in the same cycle as flush_i is ignored.
- rst_ni asserted mid-operation clears everything immediately.
- Counter counts down XLEN-1..0 and leaves CALC when it reaches 0. No wrap.
- An undefined op_i cannot occur, because op_i is 3 bits with all 8 codes defined.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
  - Defined: multiply ops skip CALC and use a single-cycle combinational XLEN×XLEN multiplier in FIX. valid_o rises at N+2, the same as the divide special cases.
  - Undefined: all multiplies use the iterative path, with valid_o at N+XLEN+2.
- Divide timing is unaffected either way.

Decomposition:
- pkg_config additions:
  - muldiv_op_e enum: MD_MUL=0, MD_MULH=1, MD_MULHSU=2, MD_MULHU=3, MD_DIV=4, MD_DIVU=5, MD_REM=6, MD_REMU=7.
  - muldiv_state_e enum: IDLE, CALC, FIX, DONE.
  - Helper function is_div(op).
- Sub-module muldiv_signfix: combinational magnitude/negate helper used on both the operand and the result side.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB. valid_o first high exactly 34 cycles after accept with XLEN=32, or 2 cycles with MULDIV_FAST_MUL_EN.
- MULH a=b=0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. DIVU a=0x80000000, b=3 → 0x2AAAAAAA.
- DIVU a=5, b=0 → 0xFFFFFFFF at 2 cycles; REMU a=5, b=0 → 5. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → valid_o and result_o stable, ready_o=0 throughout; ready_o=1 the cycle after the handshake.
- Flush at CALC cycle 5, with valid_i=1 in the same cycle → IDLE next cycle, valid_o never asserts, next request completes correctly. Assert rst_ni low mid-CALC → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Shared types and helpers for the iterative RV32M multiply/divide
//            unit: operation encoding (RV32M funct3), FSM states and
//            small decode helpers for operand signedness.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // rs1 is interpreted as signed
  function automatic logic a_signed(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as signed
  function automatic logic b_signed(input muldiv_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_signfix
// Purpose  : Conditional two's-complement negation. Used to take operand
//            magnitudes and to restore the sign of results.
// Ports    : i_val [W-1:0] value in
//            i_neg         negate when high
//            o_val [W-1:0] i_neg ? -i_val : i_val
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU,
//            DIV, DIVU, REM, REMU). Shift-add multiply and restoring divide
//            on operand magnitudes, sign restored in a FIX cycle.
//            Latency: XLEN+2 cycles from accept to valid_o; divide special
//            cases (b==0, signed overflow) take 2 cycles.
// Options  : MULDIV_FAST_MUL_EN - multiplies bypass CALC and use a single
//            combinational XLEN x XLEN multiplier in FIX (2-cycle latency).
// Params   : XLEN (=DATA_WIDTH) operand/result width, >= 4 and even.
// Ports    : clk_i, rst_ni (async, active-low), flush_i (abort),
//            valid_i/ready_o request handshake with op_i, a_i, b_i,
//            valid_o/ready_i result handshake with result_o,
//            busy_o (state != IDLE).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int DATA_WIDTH = XLEN;
  localparam int CNT_W      = $clog2(XLEN) + 1;

  muldiv_state_e         r_state, w_state_nxt;
  muldiv_op_e            r_op;
  logic                  r_neg_a, r_neg_b, r_special;
  logic [CNT_W-1:0]      r_cnt;
  // Multiply: {r_hi,r_lo} is the running product, r_lo starts as |b|, r_mag = |a|.
  // Divide:   r_hi is the partial remainder, r_lo dividend/quotient, r_mag = |b|.
  // Special:  r_hi holds the final result directly.
  logic [XLEN-1:0]       r_hi, r_lo, r_mag;
  logic [DATA_WIDTH-1:0] r_result;

  muldiv_op_e            w_op;
  logic                  w_accept, w_div, w_neg_a, w_neg_b;
  logic                  w_bzero, w_ovf, w_special, w_bypass;
  logic [XLEN-1:0]       w_mag_a, w_mag_b, w_special_val;
  logic [XLEN:0]         w_mul_sum, w_div_sh;
  logic [XLEN+1:0]       w_div_diff;
  logic [2*XLEN-1:0]     w_prod, w_fix_raw, w_fix_out;
  logic                  w_fix_neg;
  logic [XLEN-1:0]       w_fix_sel;

  // ---------------------------------------------------------------- decode
  assign w_op      = muldiv_op_e'(op_i);
  assign w_div     = is_div(w_op);
  assign w_neg_a   = a_signed(w_op) & a_i[XLEN-1];
  assign w_neg_b   = b_signed(w_op) & b_i[XLEN-1];
  assign w_bzero   = (b_i == '0);
  assign w_ovf     = a_signed(w_op) & w_div & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);
  assign w_special = w_div & (w_bzero | w_ovf);

  always_comb begin
    w_special_val = '0;
    if (w_bzero) w_special_val = is_rem(w_op) ? a_i : '1;
    else         w_special_val = is_rem(w_op) ? '0  : a_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  assign w_bypass = w_special | ~w_div;
`else
  assign w_bypass = w_special;
`endif

  muldiv_signfix #(.W(XLEN)) u_mag_a (.i_val(a_i), .i_neg(w_neg_a), .o_val(w_mag_a));
  muldiv_signfix #(.W(XLEN)) u_mag_b (.i_val(b_i), .i_neg(w_neg_b), .o_val(w_mag_b));

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    busy_o      = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (valid_i && !flush_i) begin
          w_accept    = 1'b1;
          w_state_nxt = w_bypass ? FIX : CALC;
        end
      end
      CALC:    if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  // -------------------------------------------------------- iteration step
  // Shift-add: add multiplicand when the current multiplier LSB is set, then
  // shift the whole product right, carry included.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);
  // Restoring divide: bring in next dividend bit, trial-subtract the divisor;
  // the extra top bit of w_div_diff is the borrow.
  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff = {1'b0, w_div_sh} - {2'b00, r_mag};

  // ------------------------------------------------------- result fix-up
`ifdef MULDIV_FAST_MUL_EN
  assign w_prod = {{XLEN{1'b0}}, r_mag} * {{XLEN{1'b0}}, r_lo};
`else
  assign w_prod = {r_hi, r_lo};
`endif

  // Divide results are zero-extended so one 2*XLEN negator serves all ops;
  // the low half of a negated zero-extended value is the XLEN-bit negation.
  assign w_fix_raw = is_div(r_op) ? {{XLEN{1'b0}}, (is_rem(r_op) ? r_hi : r_lo)} : w_prod;
  assign w_fix_neg = is_rem(r_op) ? r_neg_a : (r_neg_a ^ r_neg_b);

  muldiv_signfix #(.W(2*XLEN)) u_fix (.i_val(w_fix_raw), .i_neg(w_fix_neg), .o_val(w_fix_out));

  assign w_fix_sel = ((r_op == MD_MUL) || is_div(r_op)) ? w_fix_out[XLEN-1:0]
                                                        : w_fix_out[2*XLEN-1:XLEN];

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op      <= MD_MUL;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mag     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_neg_a   <= w_neg_a;
      r_neg_b   <= w_neg_b;
      r_special <= w_special;
      r_cnt     <= CNT_W'(XLEN - 1);
      r_hi      <= w_special ? w_special_val : '0;
      r_lo      <= w_div ? w_mag_a : w_mag_b;
      r_mag     <= w_div ? w_mag_b : w_mag_a;
    end else if (r_state == CALC && !flush_i) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      if (is_div(r_op)) begin
        if (!w_div_diff[XLEN+1]) begin
          r_hi <= w_div_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_sh[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end else if (r_state == FIX && !flush_i) begin
      r_result <= r_special ? r_hi : w_fix_sel;
    end
  end

  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (XLEN=32). Results and
//            latencies are compared with a 64-bit arithmetic reference model.
//            Honours MULDIV_FAST_MUL_EN for expected multiply latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int TIMEOUT = 200;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 34;
`endif
  localparam int LAT_DIV = 34;
  localparam int LAT_SPC = 2;

  logic        clk_i, rst_ni, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o, busy_o;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, result_o;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (op)
      3'd0: begin r = ua * ub; return r[31:0];  end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; r = ua / ub; return r[31:0]; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return LAT_MUL;
    if (b == 0) return LAT_SPC;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPC;
    return LAT_DIV;
  endfunction

  // Drive one request, wait (bounded) for valid_o. Returns the result seen on
  // the first valid cycle and the cycles from accept to valid (TIMEOUT if none).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk_i);
      lat++;
    end
    res = result_o;
    @(negedge clk_i);
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;
    #12;
    n_tests++;
    if ({ready_o, valid_o, busy_o, result_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%h, want 1 0 0 0",
               ready_o, valid_o, busy_o, result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    n_tests++;
    if ({ready_o, valid_o, busy_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b vld=%b busy=%b, want 1 0 0",
               ready_o, valid_o, busy_o);
    end
  endtask

  localparam logic [2:0]  D_OP [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
  localparam logic [31:0] D_A  [11] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd5,
                                        32'h8000_0000, 32'h8000_0000};
  localparam logic [31:0] D_B  [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2,
                                        32'd2, 32'd2, 32'd3, 32'd0, 32'd0,
                                        32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] D_R  [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h2AAA_AAAA, 32'hFFFF_FFFF,
                                        32'd5, 32'h8000_0000, 32'd0};
  localparam int          D_L  [11] = '{LAT_MUL, LAT_MUL, LAT_MUL, LAT_MUL, LAT_DIV, LAT_DIV,
                                        LAT_DIV, LAT_SPC, LAT_SPC, LAT_SPC, LAT_SPC};

  task automatic test_directed();
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 11; i++) begin
      do_op(D_OP[i], D_A[i], D_B[i], res, lat);
      n_tests++;
      if (res !== D_R[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] op=%0d: got %h, want %h", i, D_OP[i], res, D_R[i]);
      end
      n_tests++;
      if (lat != D_L[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d] op=%0d: got %0d, want %0d", i, D_OP[i], lat, D_L[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp_r;
    int lat, exp_l;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
        default: ;
      endcase
      exp_r = ref_model(op, a, b);
      exp_l = ref_latency(op, a, b);
      do_op(op, a, b, res, lat);
      n_tests++;
      if (res !== exp_r) begin
        n_fail++;
        $display("FAIL random_result op=%0d a=%h b=%h: got %h, want %h", op, a, b, res, exp_r);
      end
      n_tests++;
      if (lat != exp_l) begin
        n_fail++;
        $display("FAIL random_latency op=%0d a=%h b=%h: got %0d, want %0d", op, a, b, lat, exp_l);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    int bad;
    ready_i = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, res, lat);
    n_tests++;
    if (res !== 32'd14) begin
      n_fail++;
      $display("FAIL bp_result: got %h, want %h", res, 32'd14);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_o !== 1'b1 || result_o !== 32'd14 || ready_o !== 1'b0) bad++;
      @(negedge clk_i);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b, want 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk_i);
    valid_i = 1'b0;
    w = 0;
    while (valid_o !== 1'b1 && w < TIMEOUT) begin @(negedge clk_i); w++; end
    n_tests++;
    if (result_o !== 32'd15) begin
      n_fail++;
      $display("FAIL b2b_first: got %h, want %h", result_o, 32'd15);
    end
    // request offered during the DONE/handshake cycle must not be taken
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'd1000; b_i = 32'd10;
    @(negedge clk_i);
    n_tests++;
    if ({busy_o, ready_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_no_accept_in_done: got busy=%b rdy=%b, want 0 1", busy_o, ready_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    w = 0;
    while (valid_o !== 1'b1 && w < TIMEOUT) begin @(negedge clk_i); w++; end
    n_tests++;
    if (result_o !== 32'd100) begin
      n_fail++;
      $display("FAIL b2b_second: got %h, want %h", result_o, 32'd100);
    end
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat, seen;
    prev = result_o;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd7;
    @(negedge clk_i);
    valid_i = 1'b0;                       // CALC cycle 1
    repeat (4) @(negedge clk_i);          // CALC cycle 5
    flush_i = 1'b1; valid_i = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9;
    @(negedge clk_i);
    flush_i = 1'b0; valid_i = 1'b0;
    n_tests++;
    if ({busy_o, ready_o, valid_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL flush_idle: got busy=%b rdy=%b vld=%b, want 0 1 0", busy_o, ready_o, valid_o);
    end
    n_tests++;
    if (result_o !== prev) begin
      n_fail++;
      $display("FAIL flush_result_kept: got %h, want %h", result_o, prev);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_valid: valid seen %0d cycles, want 0", seen);
    end
    do_op(3'd4, 32'd1000, 32'd7, res, lat);
    n_tests++;
    if (res !== 32'd142 || lat != LAT_DIV) begin
      n_fail++;
      $display("FAIL flush_recover: got %h lat %0d, want %h lat %0d", res, lat, 32'd142, LAT_DIV);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'hDEAD_BEEF; b_i = 32'd3;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({ready_o, valid_o, busy_o, result_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b res=%h, want 1 0 0 0",
               ready_o, valid_o, busy_o, result_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_op(3'd7, 32'd100, 32'd7, res, lat);
    n_tests++;
    if (res !== 32'd2) begin
      n_fail++;
      $display("FAIL post_reset_op: got %h, want %h", res, 32'd2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
